// File: rtl/oric_pkg.sv
// Shared definitions for the Oric RAM power-up sequencer: state encoding
// and the stripe pattern the real machine's DRAM shows after power-on.
package oric_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Stripe pattern: 128 bytes of FF followed by 128 bytes of 00, repeating.
  localparam logic [7:0] STRIPE_HI  = 8'hFF;
  localparam logic [7:0] STRIPE_LO  = 8'h00;
  localparam int         STRIPE_BIT = 7;

  function automatic logic [7:0] fill_byte(input int          mode,
                                           input logic [7:0]  value,
                                           input logic [31:0] cnt);
    if (mode == 0) begin
      return value;
    end
    return (((cnt >> STRIPE_BIT) & 32'd1) == 32'd0) ? STRIPE_HI : STRIPE_LO;
  endfunction

endpackage

// File: rtl/ram_init_sequencer.sv
// Clears the whole RAM after reset, holding the CPU in reset meanwhile,
// then hands dpram port 1 to the CPU through a one-cycle register stage.
module ram_init_sequencer
  import oric_pkg::*;
#(
  parameter int         AW         = 16,
  parameter int         FILL_MODE  = 0,
  parameter logic [7:0] FILL_VALUE = 8'hFF
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  output logic [7:0]    cpu_q,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_di,
  output logic          mem_ce,
  output logic          mem_we,
  input  logic [7:0]    mem_q,
  output logic          init_done,
  output logic          cpu_reset
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t      state;
  // One extra bit so the pass ends on the MSB instead of wrapping back to 0.
  logic [AW:0] clr_cnt;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      cpu_reset <= 1'b1;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_di    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt[AW]) begin
            state     <= RUN;
            init_done <= 1'b1;
            cpu_reset <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
          end else begin
            mem_ce  <= 1'b1;
            mem_we  <= 1'b1;
            mem_a   <= clr_cnt[AW-1:0];
            mem_di  <= fill_byte(FILL_MODE, FILL_VALUE, 32'(clr_cnt));
            clr_cnt <= clr_cnt + CNT_ONE;
          end
        end
        RUN: begin
          mem_a  <= cpu_a;
          mem_di <= cpu_d;
          mem_ce <= cpu_cs;
          mem_we <= cpu_cs & cpu_we;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign cpu_q = mem_q;

endmodule

// File: tb/tb_ram_init_sequencer.sv
// Bench for ram_init_sequencer: three parameterisations, each with a dpram
// model; port-1 operations are checked against a queue of expected ops.
`timescale 1ns/1ps
module tb_ram_init_sequencer;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
  } op_t;

  int total = 0;
  int bad   = 0;

  logic clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  // A: AW=4, constant fill A5
  logic        a_reset, a_cpu_cs, a_cpu_we, a_mem_ce, a_mem_we, a_init_done, a_cpu_reset;
  logic [3:0]  a_cpu_a, a_mem_a;
  logic [7:0]  a_cpu_d, a_cpu_q, a_mem_di, a_mem_q;
  logic [7:0]  a_ram [16];
  // B: AW=9, stripe fill
  logic        b_reset, b_cpu_cs, b_cpu_we, b_mem_ce, b_mem_we, b_init_done, b_cpu_reset;
  logic [8:0]  b_cpu_a, b_mem_a;
  logic [7:0]  b_cpu_d, b_cpu_q, b_mem_di, b_mem_q;
  logic [7:0]  b_ram [512];
  // C: AW=13, default fill
  logic        c_reset, c_cpu_cs, c_cpu_we, c_mem_ce, c_mem_we, c_init_done, c_cpu_reset;
  logic [12:0] c_cpu_a, c_mem_a;
  logic [7:0]  c_cpu_d, c_cpu_q, c_mem_di, c_mem_q;
  logic [7:0]  c_ram [8192];

  ram_init_sequencer #(.AW(4), .FILL_MODE(0), .FILL_VALUE(8'hA5)) dut_a (
    .clk_48(clk_48), .reset(a_reset), .cpu_a(a_cpu_a), .cpu_d(a_cpu_d),
    .cpu_cs(a_cpu_cs), .cpu_we(a_cpu_we), .cpu_q(a_cpu_q), .mem_a(a_mem_a),
    .mem_di(a_mem_di), .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_q(a_mem_q),
    .init_done(a_init_done), .cpu_reset(a_cpu_reset));

  ram_init_sequencer #(.AW(9), .FILL_MODE(1), .FILL_VALUE(8'h11)) dut_b (
    .clk_48(clk_48), .reset(b_reset), .cpu_a(b_cpu_a), .cpu_d(b_cpu_d),
    .cpu_cs(b_cpu_cs), .cpu_we(b_cpu_we), .cpu_q(b_cpu_q), .mem_a(b_mem_a),
    .mem_di(b_mem_di), .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_q(b_mem_q),
    .init_done(b_init_done), .cpu_reset(b_cpu_reset));

  ram_init_sequencer #(.AW(13)) dut_c (
    .clk_48(clk_48), .reset(c_reset), .cpu_a(c_cpu_a), .cpu_d(c_cpu_d),
    .cpu_cs(c_cpu_cs), .cpu_we(c_cpu_we), .cpu_q(c_cpu_q), .mem_a(c_mem_a),
    .mem_di(c_mem_di), .mem_ce(c_mem_ce), .mem_we(c_mem_we), .mem_q(c_mem_q),
    .init_done(c_init_done), .cpu_reset(c_cpu_reset));

  // dpram port 1 models: synchronous write, registered read
  always @(posedge clk_48) begin
    if (a_mem_ce === 1'b1) begin
      if (a_mem_we === 1'b1) a_ram[a_mem_a] <= a_mem_di;
      a_mem_q <= a_ram[a_mem_a];
    end
    if (b_mem_ce === 1'b1) begin
      if (b_mem_we === 1'b1) b_ram[b_mem_a] <= b_mem_di;
      b_mem_q <= b_ram[b_mem_a];
    end
    if (c_mem_ce === 1'b1) begin
      if (c_mem_we === 1'b1) c_ram[c_mem_a] <= c_mem_di;
      c_mem_q <= c_ram[c_mem_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  op_t qa[$];
  op_t qc[$];
  op_t ea, ec;

  // Monitors: every port-1 operation must match the next queued expectation.
  always @(negedge clk_48) begin
    if (a_mem_ce === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_op: got op at addr %0h, required none", a_mem_a);
      end else begin
        ea = qa.pop_front();
        chk("a_op_addr", 32'(a_mem_a), 32'(ea.a));
        chk("a_op_data", 32'(a_mem_di), 32'(ea.d));
        chk("a_op_we", 32'(a_mem_we), 32'(ea.we));
      end
    end
  end

  always @(negedge clk_48) begin
    if (c_init_done === 1'b1 && c_mem_ce === 1'b1) begin
      if (qc.size() == 0) begin
        total++; bad++;
        $display("FAIL c_unexpected_op: got op at addr %0h, required none", c_mem_a);
      end else begin
        ec = qc.pop_front();
        chk("c_op_addr", 32'(c_mem_a), 32'(ec.a));
        chk("c_op_data", 32'(c_mem_di), 32'(ec.d));
        chk("c_op_we", 32'(c_mem_we), 32'(ec.we));
      end
    end
  end

  initial begin
    int n;
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    // CPU hammers zeros during A's clear; none of it may land.
    a_cpu_cs = 1'b1; a_cpu_we = 1'b1; a_cpu_d = 8'h00; a_cpu_a = 4'h9;
    b_cpu_cs = 1'b0; b_cpu_we = 1'b0; b_cpu_d = 8'h00; b_cpu_a = '0;
    c_cpu_cs = 1'b0; c_cpu_we = 1'b0; c_cpu_d = 8'h00; c_cpu_a = '0;
    repeat (3) tick();

    chk("a_rst_mem_ce", 32'(a_mem_ce), 0);
    chk("a_rst_mem_we", 32'(a_mem_we), 0);
    chk("a_rst_mem_a", 32'(a_mem_a), 0);
    chk("a_rst_mem_di", 32'(a_mem_di), 0);
    chk("a_rst_init_done", 32'(a_init_done), 0);
    chk("a_rst_cpu_reset", 32'(a_cpu_reset), 1);

    // Partial clear: 7 writes then reset reasserted.
    for (int i = 0; i < 7; i++) qa.push_back('{a: 16'(i), d: 8'hA5, we: 1'b1});
    a_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_cpu_a = 4'(i * 5);
      tick();
    end
    a_reset = 1'b1;
    repeat (4) tick();
    chk("a_abort_queue_drained", 32'(qa.size()), 0);
    chk("a_abort_init_done", 32'(a_init_done), 0);
    chk("a_abort_mem_ce", 32'(a_mem_ce), 0);

    // Full clear from address 0.
    for (int i = 0; i < 16; i++) qa.push_back('{a: 16'(i), d: 8'hA5, we: 1'b1});
    a_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_cpu_a = 4'(i * 3);
      tick();
    end
    chk("a_cycle16_init_done", 32'(a_init_done), 0);
    chk("a_cycle16_cpu_reset", 32'(a_cpu_reset), 1);
    tick();
    chk("a_cycle17_init_done", 32'(a_init_done), 1);
    chk("a_cycle17_cpu_reset", 32'(a_cpu_reset), 0);
    chk("a_clear_queue_drained", 32'(qa.size()), 0);
    a_cpu_cs = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) chk($sformatf("a_fill_%0d", i), 32'(a_ram[i]), 32'h A5);

    // RUN write to 3, then read it back.
    a_cpu_cs = 1'b1; a_cpu_we = 1'b1; a_cpu_a = 4'h3; a_cpu_d = 8'h5A;
    qa.push_back('{a: 16'h3, d: 8'h5A, we: 1'b1});
    tick();
    chk("a_run_wr_ce", 32'(a_mem_ce), 1);
    chk("a_run_wr_we", 32'(a_mem_we), 1);
    a_cpu_we = 1'b0; a_cpu_d = 8'h77;
    qa.push_back('{a: 16'h3, d: 8'h77, we: 1'b0});
    tick();
    chk("a_run_rd_ce", 32'(a_mem_ce), 1);
    chk("a_run_rd_we", 32'(a_mem_we), 0);
    a_cpu_cs = 1'b0;
    tick();
    chk("a_run_rd_q", 32'(a_cpu_q), 32'h5A);

    // Read-only access to 4 with zero data: must not modify.
    a_cpu_cs = 1'b1; a_cpu_we = 1'b0; a_cpu_a = 4'h4; a_cpu_d = 8'h00;
    qa.push_back('{a: 16'h4, d: 8'h00, we: 1'b0});
    tick();
    chk("a_rd4_we", 32'(a_mem_we), 0);
    // Write enable without chip select: no operation at all.
    a_cpu_cs = 1'b0; a_cpu_we = 1'b1; a_cpu_a = 4'h5;
    repeat (2) tick();
    chk("a_nocs_ce", 32'(a_mem_ce), 0);
    chk("a_rd4_unchanged", 32'(a_ram[4]), 32'hA5);
    chk("a_nocs_unchanged", 32'(a_ram[5]), 32'hA5);
    chk("a_rd4_q", 32'(a_cpu_q), 32'hA5);
    chk("a_run_queue_drained", 32'(qa.size()), 0);

    // Reset in RUN returns to the clearing state.
    a_cpu_we = 1'b0;
    a_reset = 1'b1;
    tick();
    chk("a_run_rst_init_done", 32'(a_init_done), 0);
    chk("a_run_rst_cpu_reset", 32'(a_cpu_reset), 1);

    // B: stripe pattern over 512 bytes.
    b_reset = 1'b0;
    n = 0;
    while (b_init_done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("b_done_cycle", 32'(n), 513);
    chk("b_cpu_reset", 32'(b_cpu_reset), 0);
    for (int i = 0; i < 512; i++)
      chk($sformatf("b_stripe_%0h", i), 32'(b_ram[i]), ((i >> 7) & 1) == 0 ? 32'hFF : 32'h00);

    // C: default FF fill, then RUN write/read at 0x1234.
    c_reset = 1'b0;
    n = 0;
    while (c_init_done !== 1'b1 && n < 8300) begin
      tick();
      n++;
    end
    chk("c_done_cycle", 32'(n), 8193);
    chk("c_fill_1234", 32'(c_ram[13'h1234]), 32'hFF);
    c_cpu_cs = 1'b1; c_cpu_we = 1'b1; c_cpu_a = 13'h1234; c_cpu_d = 8'h5A;
    qc.push_back('{a: 16'h1234, d: 8'h5A, we: 1'b1});
    tick();
    chk("c_wr_ce", 32'(c_mem_ce), 1);
    chk("c_wr_we", 32'(c_mem_we), 1);
    chk("c_wr_a", 32'(c_mem_a), 32'h1234);
    chk("c_wr_di", 32'(c_mem_di), 32'h5A);
    c_cpu_we = 1'b0; c_cpu_d = 8'h00;
    qc.push_back('{a: 16'h1234, d: 8'h00, we: 1'b0});
    tick();
    c_cpu_cs = 1'b0;
    tick();
    chk("c_rd_q", 32'(c_cpu_q), 32'h5A);
    chk("c_queue_drained", 32'(qc.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_init_sequencer.md
RAM_INIT_SEQUENCER -- requirements
Module: ram_init_sequencer

Interface
REQ-001 Parameter AW, default 16, memory address width; clear covers 2^AW locations.
REQ-002 Parameter FILL_MODE, default 0; 0 = constant fill, 1 = Oric power-up stripe pattern.
REQ-003 Parameter FILL_VALUE, default 8'hFF, constant fill byte for FILL_MODE 0.
REQ-004 clk_48  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_a  input  AW  CPU-side RAM address.
REQ-007 cpu_d  input  8  CPU-side write data.
REQ-008 cpu_cs  input  1  CPU-side chip select.
REQ-009 cpu_we  input  1  CPU-side write enable, qualified by cpu_cs.
REQ-010 cpu_q  output  8  read data to CPU, combinational copy of mem_q.
REQ-011 mem_a  output  AW  registered address to dpram port 1.
REQ-012 mem_di  output  8  registered write data to dpram port 1.
REQ-013 mem_ce  output  1  registered chip enable to dpram port 1.
REQ-014 mem_we  output  1  registered write enable to dpram port 1.
REQ-015 mem_q  input  8  dpram port 1 read data.
REQ-016 init_done  output  1  high once the clear pass has finished; low otherwise.
REQ-017 cpu_reset  output  1  active-high hold for the CPU core; equals reset OR NOT init_done, registered.

Function
REQ-018 The block SHALL have two states: CLEAR and RUN.
REQ-019 In CLEAR, each cycle SHALL register mem_ce=1, mem_we=1, mem_a=clr_cnt, mem_di=fill byte, then increment clr_cnt by 1.
REQ-020 Fill byte SHALL be FILL_VALUE when FILL_MODE=0, and 8'hFF when clr_cnt[7]=0 else 8'h00 when FILL_MODE=1.
REQ-021 clr_cnt SHALL be AW+1 bits; CLEAR→RUN transition SHALL occur on the cycle after the write to address 2^AW-1 is issued (clr_cnt MSB set); no wrap to 0 rewrite.
REQ-022 A full clear SHALL take exactly 2^AW write cycles after reset deassertion; init_done SHALL rise on cycle 2^AW+1 after reset falls.
REQ-023 In RUN, mem_a/mem_di/mem_ce/mem_we SHALL be cpu_a/cpu_d/cpu_cs/(cpu_cs AND cpu_we) delayed by exactly one clk_48 cycle.
REQ-024 In CLEAR, CPU inputs SHALL be ignored; no CPU write SHALL reach memory.
REQ-025 cpu_q SHALL equal mem_q in every state, with no added latency.
REQ-026 RUN SHALL be absorbing until reset; no other event returns to CLEAR.
REQ-027 cpu_reset SHALL be high in CLEAR and during reset, and fall on the same edge init_done rises.

Reset
REQ-028 On reset: state=CLEAR, clr_cnt=0, init_done=0, cpu_reset=1, mem_ce=0, mem_we=0, mem_a=0, mem_di=0.
REQ-029 While reset is held, no memory write SHALL be issued and clr_cnt SHALL stay 0.
REQ-030 Reset asserted mid-clear or in RUN SHALL abandon the pass; the next clear SHALL restart from address 0 after release.

Structure
REQ-031 State encoding (CLEAR, RUN) and the Oric stripe pattern constants SHALL live in the shared oric_pkg package.
REQ-032 Single module; no sub-module, all logic in one clocked process plus the cpu_q assignment.

Verification
REQ-033 AW=4, FILL_MODE=0, FILL_VALUE=8'hA5: release reset → 16 consecutive writes of A5 to addresses 0..15, init_done high on cycle 17, cpu_reset low same cycle.
REQ-034 AW=9, FILL_MODE=1: after clear, memory model holds FF at 0x000-0x07F, 00 at 0x080-0x0FF, FF at 0x100-0x17F, 00 at 0x180-0x1FF.
REQ-035 RUN: cpu_cs=1, cpu_we=1, cpu_a=0x1234, cpu_d=0x5A at cycle N → mem_ce=1, mem_we=1, mem_a=0x1234, mem_di=0x5A at cycle N+1; later read returns 0x5A on cpu_q.
REQ-036 AW=4: reset reasserted after 7 clear writes → no writes while high; after release, writes restart at address 0 and 16 further writes occur before init_done.
REQ-037 During CLEAR drive cpu_cs=1, cpu_we=1, cpu_d=0x00 every cycle → all locations still hold fill byte after init_done.
REQ-038 RUN with cpu_cs=1, cpu_we=0 → mem_we=0, mem_ce=1 one cycle later; memory contents unchanged.
